mem_stage_ctrl: RTL
===================

Name: mem_stage_ctrl

Overview:
- Memory-stage controller. It consumes the ALU/MEM pipeline buffer outputs and performs data-memory and stack accesses over a req/ack handshake.
- Sequences two-beat 32-bit PC push/pop (CALL/RET/INT/RTI) on the 16-bit data bus.
- Freezes upstream pipeline buffers while an access is in flight.
- Presents registered results toward the MEM/WB buffer.

Parameters:
- WbSize, 2, width of write-back control bundle (passed through)
- MemSize, 6, width of memory control bundle
- flagSize, 4, width of flag bundle (passed through)
- ADDR_W, 20, data-memory word-address width
- SP_INIT, 2**20-1, stack pointer reset value (top of memory)

Ports:
- clk  in  1  clock; all state on posedge
- rst  in  1  asynchronous, active-low reset
- i_Mem  in  MemSize  memory control: [0] rd, [1] wr, [2] stack, [3] dbl (32-bit pc beat pair), [4] pc_load, [5] reserved (must be 0)
- i_WB  in  WbSize  write-back control
- i_pc  in  32  pc of instruction (push data for dbl writes)
- i_Rdst  in  3  destination register
- i_alu  in  16  ALU result / effective address
- i_read_data1  in  16  store data for single-word writes
- i_flag  in  flagSize  flags
- dm_req  out  1  memory request, held until ack
- dm_we  out  1  write enable, valid with dm_req
- dm_addr  out  ADDR_W  word address
- dm_wdata  out  16  write data
- dm_rdata  in  16  read data, valid with dm_ack
- dm_ack  in  1  one-cycle acknowledge, one per beat
- o_stall  out  1  freeze upstream buffers (drive their enable low)
- o_valid  out  1  outputs below hold a completed instruction
- o_WB, o_Rdst, o_flag  out  —  registered pass-through
- o_data  out  16  read data for rd, else i_alu
- o_pc  out  32  popped pc when pc_load, else i_pc
- o_pc_load  out  1  o_pc must redirect fetch
- o_sp  out  ADDR_W  current stack pointer (debug)

Behaviour:
- Reset (rst=0, async): state IDLE, SP=SP_INIT, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, all o_* = 0.
- States: IDLE, ACC0, ACC1.
- o_stall = (state != IDLE), decoded from registered state only. Upstream negedge buffer therefore loads the next instruction only after the final-ack posedge, so no instruction re-executes.
- IDLE, rd=wr=0:
  - Capture pass-through fields; o_data=i_alu, o_pc=i_pc, o_pc_load=0.
  - o_valid=1 next posedge. Latency 1.
- IDLE, rd|wr=1:
  - Latch instruction, drive dm_req=1, go to ACC0. o_valid=0 while busy (bubble).
  - Address for non-stack: i_alu zero-extended to ADDR_W.
  - Stack push (wr, stack): beat0 addr=SP; for dbl beat1 addr=SP-1.
  - Stack pop (rd, stack): beat0 addr=SP+1; for dbl beat1 addr=SP+2.
  - Write data: non-dbl writes i_read_data1. dbl push writes i_pc[31:16] at beat0, i_pc[15:0] at beat1.
- ACC0:
  - On dm_ack: if dbl, capture the beat and go to ACC1 with dm_req kept high and new addr/data; else complete.
  - dm_req, dm_addr, dm_we, dm_wdata stable until ack.
- ACC1: on dm_ack, complete.
- Pop word order (dbl): beat0 read gives o_pc[15:0], beat1 read gives o_pc[31:16].
- Completion posedge:
  - Register outputs; o_valid=1, dm_req=0, state IDLE.
  - SP -= 1 (push) or SP += 1 (pop), by 2 for dbl.
  - o_pc_load = pc_load bit.
- SP arithmetic is modulo 2**ADDR_W; wrap is silent.
- rd and wr both set: treat as write.
- rd|wr with reserved bit set: undefined, not checked.
- Ack when dm_req=0: ignored.
- Reset mid-access: abort immediately, no SP update, dm_req drops asynchronously.

Optional Feature:
- MEM_STAGE_EXC_EN defined:
  - Adds o_exc (1) and o_exc_pc (32).
  - A pop that would move SP past SP_INIT does not issue dm_req.
  - Instead o_exc pulses one cycle with o_exc_pc=i_pc, o_valid=0, SP unchanged; latency 1 from IDLE.
- Undefined: no ports added; the pop proceeds and SP wraps.

Decomposition:
- Shared package holds:
  - MEM_RD/WR/STACK/DBL/PCLOAD bit-index constants
  - state encoding
  - SP_INIT default
  - a typedef for the memory control bundle
- One natural sub-module: mem_sp_unit. It holds SP and computes the beat addresses and next-SP from op/dbl/beat.

Test Plan:
- Reset, then ALU op i_alu=16'h1234 with no memory bits -> next posedge o_valid=1, o_data=16'h1234, o_stall never high.
- Load i_alu=16'h0040, memory returns 16'hBEEF with ack after 3 cycles -> dm_addr=20'h00040, o_stall high 3 cycles, o_data=16'hBEEF, o_valid=1 one posedge after ack.
- CALL push, i_pc=32'h0001_2345, SP=20'hFFFFF:
  - writes 16'h0001 @FFFFF, then 16'h2345 @FFFFE
  - SP=20'hFFFFD after completion; o_stall high through both acks
- RET pop from SP=20'hFFFFD, memory returns 16'h2345 then 16'h0001 -> o_pc=32'h0001_2345, o_pc_load=1, SP=20'hFFFFF.
- rst asserted during ACC1 of a push -> dm_req=0 and o_stall=0 at once, SP=SP_INIT, o_valid=0.
- With MEM_STAGE_EXC_EN: pop at SP=SP_INIT -> no dm_req, o_exc=1 for one cycle, o_exc_pc=i_pc, SP unchanged.

Source files
------------

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the memory-stage controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: memory-control bit indices, FSM state encoding, stack-pointer
// reset default and a packed view of the memory-control bundle.
package mem_stage_ctrl_pkg;

    localparam int MEM_RD     = 0;
    localparam int MEM_WR     = 1;
    localparam int MEM_STACK  = 2;
    localparam int MEM_DBL    = 3;
    localparam int MEM_PCLOAD = 4;
    localparam int MEM_RSVD   = 5;

    localparam logic [19:0] SP_INIT_DEF = 20'hFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2
    } state_e;

    // Field order mirrors the MEM_* bit indices (bit 0 = rd).
    typedef struct packed {
        logic rsvd;
        logic pc_load;
        logic dbl;
        logic stack;
        logic wr;
        logic rd;
    } mem_ctrl_t;

endpackage

// File: rtl/mem_stage_ctrl_sp.sv
// Stack-pointer unit: holds SP and derives beat addresses and next SP.
// Latency: addresses are combinational from SP; SP updates on the upd_i edge.
// Backpressure: none; the owner asserts upd_i only on access completion.
// Ports: clk/rst, push_i (push vs pop), dbl_i (two-beat op), upd_i (commit),
// sp_o, addr0_o/addr1_o (beat addresses); pop_ovf_o only with MEM_STAGE_EXC_EN.
module mem_sp_unit
    import mem_stage_ctrl_pkg::*;
#(
    parameter int                ADDR_W  = 20,
    parameter logic [ADDR_W-1:0] SP_INIT = SP_INIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              dbl_i,
    input  logic              upd_i,
    output logic [ADDR_W-1:0] sp_o,
    output logic [ADDR_W-1:0] addr0_o,
    output logic [ADDR_W-1:0] addr1_o
`ifdef MEM_STAGE_EXC_EN
    ,
    output logic              pop_ovf_o
`endif
);

    logic [ADDR_W-1:0] sp_q;
    logic [ADDR_W-1:0] sp_d;
    logic [ADDR_W-1:0] step;

    // Push writes at SP then SP-1 (SP points at the next free word);
    // pop reads SP+1 then SP+2. All arithmetic wraps modulo 2**ADDR_W.
    always_comb begin
        step    = dbl_i ? ADDR_W'(2) : ADDR_W'(1);
        addr0_o = push_i ? sp_q : sp_q + ADDR_W'(1);
        addr1_o = push_i ? sp_q - ADDR_W'(1) : sp_q + ADDR_W'(2);
        sp_d    = push_i ? sp_q - step : sp_q + step;
    end

`ifdef MEM_STAGE_EXC_EN
    // A pop overruns when fewer than 'step' words sit between SP and the top.
    logic [ADDR_W-1:0] headroom;
    always_comb begin
        headroom  = SP_INIT - sp_q;
        pop_ovf_o = (headroom < step);
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q <= SP_INIT;
        end else if (upd_i) begin
            sp_q <= sp_d;
        end
    end

    assign sp_o = sp_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: data-memory and stack accesses, two-beat PC push/pop.
// Latency: 1 cycle for ALU ops; memory ops complete one posedge after the last dm_ack.
// Backpressure: o_stall (registered state != IDLE) freezes upstream buffers while busy.
// Ports: pipeline inputs i_Mem/i_WB/i_pc/i_Rdst/i_alu/i_read_data1/i_flag;
// memory port dm_req/dm_we/dm_addr/dm_wdata/dm_rdata/dm_ack; registered results o_*.
// Option: define MEM_STAGE_EXC_EN to add o_exc/o_exc_pc and trap pops past SP_INIT.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int                WbSize   = 2,
    parameter int                MemSize  = 6,
    parameter int                flagSize = 4,
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] SP_INIT  = SP_INIT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [MemSize-1:0]  i_Mem,
    input  logic [WbSize-1:0]   i_WB,
    input  logic [31:0]         i_pc,
    input  logic [2:0]          i_Rdst,
    input  logic [15:0]         i_alu,
    input  logic [15:0]         i_read_data1,
    input  logic [flagSize-1:0] i_flag,
    output logic                dm_req,
    output logic                dm_we,
    output logic [ADDR_W-1:0]   dm_addr,
    output logic [15:0]         dm_wdata,
    input  logic [15:0]         dm_rdata,
    input  logic                dm_ack,
    output logic                o_stall,
    output logic                o_valid,
    output logic [WbSize-1:0]   o_WB,
    output logic [2:0]          o_Rdst,
    output logic [flagSize-1:0] o_flag,
    output logic [15:0]         o_data,
    output logic [31:0]         o_pc,
    output logic                o_pc_load,
    output logic [ADDR_W-1:0]   o_sp
`ifdef MEM_STAGE_EXC_EN
    ,
    output logic                o_exc,
    output logic [31:0]         o_exc_pc
`endif
);

    state_e              state_q;
    mem_ctrl_t           mem_q;
    logic [31:0]         pc_q;
    logic [15:0]         alu_q;
    logic [15:0]         lo_q;
    logic                dm_req_q, dm_we_q;
    logic [ADDR_W-1:0]   dm_addr_q;
    logic [15:0]         dm_wdata_q;
    logic                o_valid_q, o_pc_load_q;
    logic [WbSize-1:0]   o_wb_q;
    logic [2:0]          o_rdst_q;
    logic [flagSize-1:0] o_flag_q;
    logic [15:0]         o_data_q;
    logic [31:0]         o_pc_q;

    mem_ctrl_t           mem_in;
    logic                idle, acc_in, push_in, pop_in, done;
    logic                sp_push, sp_dbl, sp_upd;
    logic [ADDR_W-1:0]   sp_addr0, sp_addr1, addr0, addr1;
    logic [15:0]         wdata0, data_res;
    logic [31:0]         pc_res;

    assign mem_in = mem_ctrl_t'(i_Mem);

    always_comb begin
        idle     = (state_q == ST_IDLE);
        // Reserved encodings never start an access; they fall through as ALU ops.
        acc_in   = (mem_in.rd | mem_in.wr) & ~mem_in.rsvd;
        push_in  = mem_in.wr & mem_in.stack;
        pop_in   = mem_in.rd & ~mem_in.wr & mem_in.stack;
        // SP unit sees the incoming op while idle and the latched op while busy.
        sp_push  = idle ? push_in : (mem_q.wr & mem_q.stack);
        sp_dbl   = idle ? mem_in.dbl : mem_q.dbl;
        done     = dm_ack & (((state_q == ST_ACC0) & ~mem_q.dbl) | (state_q == ST_ACC1));
        sp_upd   = done & mem_q.stack;
        addr0    = mem_in.stack ? sp_addr0 : ADDR_W'(i_alu);
        addr1    = mem_q.stack ? sp_addr1 : dm_addr_q + ADDR_W'(1);
        wdata0   = mem_in.dbl ? i_pc[31:16] : i_read_data1;
        data_res = (mem_q.rd & ~mem_q.wr) ? dm_rdata : alu_q;
        // Popped PC: first beat is the low half, second beat the high half.
        if (mem_q.pc_load) begin
            pc_res = mem_q.dbl ? {dm_rdata, lo_q} : {16'h0000, dm_rdata};
        end else begin
            pc_res = pc_q;
        end
    end

`ifdef MEM_STAGE_EXC_EN
    logic pop_ovf, exc_in;
    logic o_exc_q;
    logic [31:0] o_exc_pc_q;
    assign exc_in   = acc_in & pop_in & pop_ovf;
    assign o_exc    = o_exc_q;
    assign o_exc_pc = o_exc_pc_q;
`endif

    mem_sp_unit #(
        .ADDR_W  (ADDR_W),
        .SP_INIT (SP_INIT)
    ) u_sp (
        .clk       (clk),
        .rst       (rst),
        .push_i    (sp_push),
        .dbl_i     (sp_dbl),
        .upd_i     (sp_upd),
        .sp_o      (o_sp),
        .addr0_o   (sp_addr0),
        .addr1_o   (sp_addr1)
`ifdef MEM_STAGE_EXC_EN
        ,
        .pop_ovf_o (pop_ovf)
`endif
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mem_q       <= '0;
            pc_q        <= '0;
            alu_q       <= '0;
            lo_q        <= '0;
            dm_req_q    <= 1'b0;
            dm_we_q     <= 1'b0;
            dm_addr_q   <= '0;
            dm_wdata_q  <= '0;
            o_valid_q   <= 1'b0;
            o_pc_load_q <= 1'b0;
            o_wb_q      <= '0;
            o_rdst_q    <= '0;
            o_flag_q    <= '0;
            o_data_q    <= '0;
            o_pc_q      <= '0;
`ifdef MEM_STAGE_EXC_EN
            o_exc_q     <= 1'b0;
            o_exc_pc_q  <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
`ifdef MEM_STAGE_EXC_EN
                    o_exc_q <= 1'b0;
                    if (exc_in) begin
                        // Trap instead of popping beyond the top of stack.
                        o_valid_q  <= 1'b0;
                        o_exc_q    <= 1'b1;
                        o_exc_pc_q <= i_pc;
                    end else
`endif
                    if (acc_in) begin
                        mem_q      <= mem_in;
                        pc_q       <= i_pc;
                        alu_q      <= i_alu;
                        o_wb_q     <= i_WB;
                        o_rdst_q   <= i_Rdst;
                        o_flag_q   <= i_flag;
                        dm_req_q   <= 1'b1;
                        dm_we_q    <= mem_in.wr;
                        dm_addr_q  <= addr0;
                        dm_wdata_q <= wdata0;
                        o_valid_q  <= 1'b0;
                        state_q    <= ST_ACC0;
                    end else begin
                        o_valid_q   <= 1'b1;
                        o_wb_q      <= i_WB;
                        o_rdst_q    <= i_Rdst;
                        o_flag_q    <= i_flag;
                        o_data_q    <= i_alu;
                        o_pc_q      <= i_pc;
                        o_pc_load_q <= 1'b0;
                    end
                end
                ST_ACC0: begin
                    if (dm_ack && mem_q.dbl) begin
                        lo_q       <= dm_rdata;
                        dm_addr_q  <= addr1;
                        dm_wdata_q <= pc_q[15:0];
                        state_q    <= ST_ACC1;
                    end
                end
                ST_ACC1: ;
                default: state_q <= ST_IDLE;
            endcase

            // Final beat acknowledged: publish the result and release the stall.
            if (done) begin
                o_valid_q   <= 1'b1;
                dm_req_q    <= 1'b0;
                dm_we_q     <= 1'b0;
                o_data_q    <= data_res;
                o_pc_q      <= pc_res;
                o_pc_load_q <= mem_q.pc_load;
                state_q     <= ST_IDLE;
            end
        end
    end

    assign o_stall   = (state_q != ST_IDLE);
    assign dm_req    = dm_req_q;
    assign dm_we     = dm_we_q;
    assign dm_addr   = dm_addr_q;
    assign dm_wdata  = dm_wdata_q;
    assign o_valid   = o_valid_q;
    assign o_WB      = o_wb_q;
    assign o_Rdst    = o_rdst_q;
    assign o_flag    = o_flag_q;
    assign o_data    = o_data_q;
    assign o_pc      = o_pc_q;
    assign o_pc_load = o_pc_load_q;

endmodule
